sr_write_seq: RTL and testbench

SR_WRITE_SEQ -- requirements
Module: sr_write_seq

---
 rtl/sr_pkg.sv | 19 +
 rtl/sr_strobe_dec.sv | 22 ++
 rtl/sr_write_seq.sv | 136 +++++++++++++
 tb/tb_sr_write_seq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared state encoding and default sizing for the SR storage-array write sequencer.
package sr_pkg;
   localparam int N_CELLS_DEF   = 8;
   localparam int PULSE_CYC_DEF = 2;
   localparam int CLR_CYC_DEF   = 3;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      HOLD,
      CLEAR,
      FIN
   } sr_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction
endpackage

// File: rtl/sr_strobe_dec.sv
// One-hot set/reset strobe decode; an address outside the array selects no cell.
module sr_strobe_dec #(
   parameter int N_CELLS = 8,
   parameter int ADDR_W  = 4
) (
   input  logic                en_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic                data_i,
   output logic [N_CELLS-1:0]  s_o,
   output logic [N_CELLS-1:0]  r_o
);
   always_comb begin
      s_o = '0;
      r_o = '0;
      for (int i = 0; i < N_CELLS; i++) begin
         if (en_i && (addr_i == ADDR_W'(i))) begin
            s_o[i] = data_i;
            r_o[i] = ~data_i;
         end
      end
   end
endmodule

// File: rtl/sr_write_seq.sv
// Write/clear sequencer for an array of SR storage cells, with a shadow copy of the array.
//
//   state | meaning
//   IDLE  | ready; waits for clr (priority) or req; forces a clear after reset
//   SETUP | one quiet cycle before the strobe
//   PULSE | set or reset strobe on the captured cell for PULSE_CYC cycles
//   HOLD  | one quiet cycle; shadow already holds the new bit
//   CLEAR | is0 asserted for CLR_CYC cycles; shadow zeroed on exit
//   FIN   | done pulse, back to IDLE
module sr_write_seq
   import sr_pkg::*;
#(
   parameter int N_CELLS   = N_CELLS_DEF,
   parameter int PULSE_CYC = PULSE_CYC_DEF,
   parameter int CLR_CYC   = CLR_CYC_DEF,
   // One extra bit so that addresses beyond the array can be presented and ignored.
   parameter int ADDR_W    = $clog2(N_CELLS) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req,
   input  logic [ADDR_W-1:0]   addr,
   input  logic                data,
   input  logic                clr,
   output logic                ready,
   output logic [N_CELLS-1:0]  s_bus,
   output logic [N_CELLS-1:0]  r_bus,
   output logic                is0,
   output logic                done,
   output logic [N_CELLS-1:0]  shadow
);
   localparam int CNT_W = $clog2(max_int(PULSE_CYC, CLR_CYC) + 1);

   sr_state_e            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 data_q, data_d;
   logic                 init_q, init_d;
   logic [N_CELLS-1:0]   shadow_q, shadow_d;
   logic                 ready_q, is0_q, done_q;
   logic [N_CELLS-1:0]   s_q, r_q, s_d, r_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      init_d   = init_q;
      shadow_d = shadow_q;
      case (state_q)
         IDLE: begin
            if (init_q || (ready_q && clr)) begin
               state_d = CLEAR;
               cnt_d   = CNT_W'(CLR_CYC - 1);
               init_d  = 1'b0;
            end else if (ready_q && req) begin
               state_d = SETUP;
               addr_d  = addr;
               data_d  = data;
            end
         end
         SETUP: begin
            state_d = PULSE;
            cnt_d   = CNT_W'(PULSE_CYC - 1);
         end
         PULSE: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               for (int i = 0; i < N_CELLS; i++) begin
                  if (addr_q == ADDR_W'(i)) shadow_d[i] = data_q;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD: state_d = FIN;
         CLEAR: begin
            if (cnt_q == '0) begin
               state_d  = FIN;
               shadow_d = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes are decoded from next-state values so every output leaves a flop.
   sr_strobe_dec #(
      .N_CELLS (N_CELLS),
      .ADDR_W  (ADDR_W)
   ) u_dec (
      .en_i   (state_d == PULSE),
      .addr_i (addr_d),
      .data_i (data_d),
      .s_o    (s_d),
      .r_o    (r_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         data_q   <= 1'b0;
         init_q   <= 1'b1;
         shadow_q <= '0;
         ready_q  <= 1'b0;
         is0_q    <= 1'b1;
         done_q   <= 1'b0;
         s_q      <= '0;
         r_q      <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         init_q   <= init_d;
         shadow_q <= shadow_d;
         ready_q  <= (state_d == IDLE) && !init_d;
         is0_q    <= (state_d == CLEAR);
         done_q   <= (state_d == FIN);
         s_q      <= s_d;
         r_q      <= r_d;
      end
   end

   assign ready  = ready_q;
   assign s_bus  = s_q;
   assign r_bus  = r_q;
   assign is0    = is0_q;
   assign done   = done_q;
   assign shadow = shadow_q;
endmodule

// File: tb/tb_sr_write_seq.sv
// Bench for sr_write_seq: queue-based cycle model checked every cycle, plus directed literal checks.
module tb_sr_write_seq;
   localparam int N  = 8;
   localparam int P  = 2;
   localparam int C  = 3;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req = 1'b0;
   logic          clr = 1'b0;
   logic          data = 1'b0;
   logic [AW-1:0] addr = '0;
   logic          ready, is0, done;
   logic [N-1:0]  s_bus, r_bus, shadow;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sr_write_seq dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .addr   (addr),
      .data   (data),
      .clr    (clr),
      .ready  (ready),
      .s_bus  (s_bus),
      .r_bus  (r_bus),
      .is0    (is0),
      .done   (done),
      .shadow (shadow)
   );

   typedef struct packed {
      logic         rdy;
      logic         z;
      logic         dn;
      logic [N-1:0] s;
      logic [N-1:0] r;
      logic [N-1:0] sh;
   } exp_t;

   // Model: a queue of expected outputs for each cycle of the operation in flight.
   exp_t         q[$];
   logic         pend_init = 1'b1;
   logic [N-1:0] m_sh = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic z, input logic dn, input logic [N-1:0] s,
                               input logic [N-1:0] r, input logic [N-1:0] sh);
      exp_t e;
      e.rdy = 1'b0; e.z = z; e.dn = dn; e.s = s; e.r = r; e.sh = sh;
      return e;
   endfunction

   function automatic void push_clear();
      for (int i = 0; i < C; i++) q.push_back(mk(1'b1, 1'b0, '0, '0, m_sh));
      m_sh = '0;
      q.push_back(mk(1'b0, 1'b1, '0, '0, m_sh));
   endfunction

   function automatic void push_write(input logic [AW-1:0] a, input logic d);
      logic [N-1:0] v;
      v = '0;
      if (int'(a) < N) v[a[2:0]] = 1'b1;
      q.push_back(mk(1'b0, 1'b0, '0, '0, m_sh));
      for (int i = 0; i < P; i++) q.push_back(mk(1'b0, 1'b0, d ? v : '0, d ? '0 : v, m_sh));
      if (int'(a) < N) m_sh[a[2:0]] = d;
      q.push_back(mk(1'b0, 1'b0, '0, '0, m_sh));
      q.push_back(mk(1'b0, 1'b1, '0, '0, m_sh));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         pend_init = 1'b1;
         m_sh = '0;
      end else if (pend_init) begin
         push_clear();
         pend_init = 1'b0;
      end else if (q.size() != 0) begin
         void'(q.pop_front());
      end else if (clr) begin
         push_clear();
      end else if (req) begin
         push_write(addr, data);
      end
   end

   always @(negedge clk) begin
      exp_t e;
      exp_t g;
      if (!rst_n || pend_init) begin
         e = mk(1'b1, 1'b0, '0, '0, '0);
      end else if (q.size() == 0) begin
         e = mk(1'b0, 1'b0, '0, '0, m_sh);
         e.rdy = 1'b1;
      end else begin
         e = q[0];
      end
      g = {ready, is0, done, s_bus, r_bus, shadow};
      chk("cycle{rdy,is0,done,s,r,sh}", 32'(g), 32'(e));
      chk("strobe_onehot0", 32'($onehot0(s_bus | r_bus)), 32'd1);
   end

   task automatic op(input logic r, input logic c, input logic [AW-1:0] a, input logic d);
      @(negedge clk);
      req = r; clr = c; addr = a; data = d;
      @(posedge clk);
      #1;
      req = 1'b0; clr = 1'b0; addr = AW'($urandom); data = ~d;
   endtask

   task automatic watch(output int lat, output logic [N-1:0] so, output logic [N-1:0] ro,
                        output int sc, output int rc, output int ic);
      lat = 0; so = '0; ro = '0; sc = 0; rc = 0; ic = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         lat++;
         so |= s_bus;
         ro |= r_bus;
         if (|s_bus) sc++;
         if (|r_bus) rc++;
         if (is0) ic++;
         if (done) return;
      end
      checks++;
      failures++;
      $display("FAIL watch_timeout got=no_done exp=done within 40 cycles");
   endtask

   initial begin
      int lat, sc, rc, ic;
      logic [N-1:0] so, ro;

      repeat (3) @(negedge clk);
      chk("rst_is0", 32'(is0), 32'd1);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_strobes", 32'(s_bus | r_bus), 32'd0);
      chk("rst_shadow", 32'(shadow), 32'd0);
      #1 rst_n = 1'b1;
      watch(lat, so, ro, sc, rc, ic);
      chk("init_is0_cycles", 32'(ic), 32'd3);
      chk("init_latency", 32'(lat), 32'd4);
      @(negedge clk);
      chk("init_ready", 32'(ready), 32'd1);
      chk("init_shadow", 32'(shadow), 32'h00);

      op(1'b1, 1'b0, 4'd5, 1'b1);
      watch(lat, so, ro, sc, rc, ic);
      chk("set5_latency", 32'(lat), 32'd5);
      chk("set5_s_bus", 32'(so), 32'h20);
      chk("set5_s_cycles", 32'(sc), 32'd2);
      chk("set5_r_bus", 32'(ro), 32'h00);
      chk("set5_shadow", 32'(shadow), 32'h20);

      op(1'b1, 1'b0, 4'd5, 1'b0);
      watch(lat, so, ro, sc, rc, ic);
      chk("rst5_latency", 32'(lat), 32'd5);
      chk("rst5_r_bus", 32'(ro), 32'h20);
      chk("rst5_r_cycles", 32'(rc), 32'd2);
      chk("rst5_s_bus", 32'(so), 32'h00);
      chk("rst5_shadow", 32'(shadow), 32'h00);

      @(negedge clk);
      req = 1'b1; clr = 1'b1; addr = 4'd2; data = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      watch(lat, so, ro, sc, rc, ic);
      chk("both_clear_latency", 32'(lat), 32'd4);
      chk("both_clear_is0", 32'(ic), 32'd3);
      chk("both_clear_strobes", 32'(so | ro), 32'h00);
      @(negedge clk);
      chk("both_ready_after", 32'(ready), 32'd1);
      @(posedge clk);
      #1 req = 1'b0;
      watch(lat, so, ro, sc, rc, ic);
      chk("both_req_latency", 32'(lat), 32'd5);
      chk("both_req_s_bus", 32'(so), 32'h04);
      chk("both_req_shadow", 32'(shadow), 32'h04);

      op(1'b1, 1'b0, 4'd9, 1'b1);
      watch(lat, so, ro, sc, rc, ic);
      chk("oor_latency", 32'(lat), 32'd5);
      chk("oor_strobes", 32'(so | ro), 32'h00);
      chk("oor_shadow", 32'(shadow), 32'h04);

      op(1'b1, 1'b0, 4'd3, 1'b1);
      @(posedge clk);
      #1 chk("midrst_pulse_on", 32'(s_bus), 32'h08);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_s_drop", 32'(s_bus), 32'h00);
      chk("midrst_r_drop", 32'(r_bus), 32'h00);
      chk("midrst_is0", 32'(is0), 32'd1);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      watch(lat, so, ro, sc, rc, ic);
      chk("midrst_clear_is0", 32'(ic), 32'd3);
      chk("midrst_shadow", 32'(shadow), 32'h00);

      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         req  = ($urandom_range(0, 2) == 0);
         clr  = ($urandom_range(0, 11) == 0);
         addr = AW'($urandom_range(0, 9));
         data = 1'($urandom_range(0, 1));
         if (cyc == 700) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #1 rst_n = 1'b1;
         end
      end
      req = 1'b0;
      clr = 1'b0;
      repeat (12) @(negedge clk);
      chk("final_idle_ready", 32'(ready), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
